// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle main controller and the datapath/memory.
// The master side is the controller; the slave side is the datapath it steers.
interface main_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             RegWrite;
  logic             IllegalOp;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  op, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, RegWrite, IllegalOp, InstrCount
  );

  modport slave (
    output op, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, RegWrite, IllegalOp, InstrCount
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle main controller: steps each instruction through fetch/decode/execute/
// memory/writeback, drives datapath selects and strobes, traps illegal opcodes, counts retires.
module main_fsm #(
  parameter int CNT_W        = 32,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  main_fsm_if.master bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    JAL    = 4'd8,
    ALUWB  = 4'd9,
    BEQ    = 4'd10,
    HALT   = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       adr_src, mem_write, ir_write, pc_update, branch, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;

    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        pc_update  = bus.MemReady;
        state_d    = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_JAL:            state_d = JAL;
          OP_BEQ:            state_d = BEQ;
          default:           state_d = TRAP_ILLEGAL ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OP_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = bus.MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        // The write request stays up until memory accepts it.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = bus.MemReady ? FETCH : MEMWR;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      HALT: begin
        illegal_op = 1'b1;
        state_d    = HALT;
      end
      default: state_d = FETCH;
    endcase

    count_d = count_q;
    if ((state_q != FETCH) && (state_d == FETCH)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Strobes are squashed while reset is held; state already shows FETCH selects then.
  assign bus.PCWrite    = rst_n & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite    = rst_n & ir_write;
  assign bus.RegWrite   = rst_n & reg_write;
  assign bus.MemWrite   = rst_n & mem_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUOp      = alu_op;
  assign bus.IllegalOp  = illegal_op;
  assign bus.InstrCount = count_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: two instances (32-bit counter with trap, 4-bit counter
// without trap) share random stimulus; expected per-cycle outputs come from an instruction-level model.
module tb_main_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                P_EXECR, P_EXECI, P_JAL, P_ALUWB, P_BEQ, P_HALT} phase_t;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic       rw;
    logic       ill;
  } outv_t;

  typedef struct {
    outv_t       o;
    logic [31:0] cnt;
    phase_t      ph;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cycNo  = 0;
  logic [31:0] cntA   = '0;
  logic [3:0]  cntB   = '0;
  exp_t        qA[$];
  exp_t        qB[$];

  main_fsm_if #(.CNT_W(32)) busA();
  main_fsm_if #(.CNT_W(4))  busB();

  main_fsm #(.CNT_W(32), .TRAP_ILLEGAL(1'b1)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  main_fsm #(.CNT_W(4),  .TRAP_ILLEGAL(1'b0)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  outv_t actA, actB;
  assign actA = {busA.PCWrite, busA.AdrSrc, busA.MemWrite, busA.IRWrite, busA.ResultSrc,
                 busA.ALUSrcA, busA.ALUSrcB, busA.ALUOp, busA.RegWrite, busA.IllegalOp};
  assign actB = {busB.PCWrite, busB.AdrSrc, busB.MemWrite, busB.IRWrite, busB.ResultSrc,
                 busB.ALUSrcA, busB.ALUSrcB, busB.ALUOp, busB.RegWrite, busB.IllegalOp};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Output table of each step of an instruction, straight from the controller's truth table.
  function automatic outv_t phaseOut(phase_t p, logic mr, logic z);
    outv_t e;
    e = '0;
    case (p)
      P_FETCH:  begin e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
      P_DECODE: begin e.sa = 2'b01; e.sb = 2'b01; end
      P_MEMADR: begin e.sa = 2'b10; e.sb = 2'b01; end
      P_MEMRD:  e.adr = 1'b1;
      P_MEMWB:  begin e.rs = 2'b01; e.rw = 1'b1; end
      P_MEMWR:  begin e.adr = 1'b1; e.mw = 1'b1; end
      P_EXECR:  begin e.sa = 2'b10; e.aop = 2'b10; end
      P_EXECI:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
      P_JAL:    begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      P_ALUWB:  e.rw = 1'b1;
      P_BEQ:    begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = z; end
      P_HALT:   e.ill = 1'b1;
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic checkOutput(string name, int cyc, outv_t act, outv_t req,
                             logic [31:0] actCnt, logic [31:0] reqCnt);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d outputs actual=%h required=%h", name, cyc, act, req);
    end
    checks++;
    if (actCnt !== reqCnt) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d InstrCount actual=%0d required=%0d", name, cyc, actCnt, reqCnt);
    end
  endtask

  task automatic applyInputs(logic [6:0] op, logic mr, logic z);
    busA.op = op; busA.MemReady = mr; busA.Zero = z;
    busB.op = op; busB.MemReady = mr; busB.Zero = z;
  endtask

  // One clock of stimulus; the expected outputs for that cycle go to each scoreboard.
  task automatic applyStimulus(phase_t pa, phase_t pb, logic [6:0] op, logic mr, logic z);
    exp_t e;
    @(posedge clk);
    #1;
    applyInputs(op, mr, z);
    cycNo++;
    e.cyc = cycNo;
    e.o = phaseOut(pa, mr, z); e.cnt = cntA;         e.ph = pa; qA.push_back(e);
    e.o = phaseOut(pb, mr, z); e.cnt = 32'(cntB);    e.ph = pb; qB.push_back(e);
  endtask

  task automatic stepBoth(phase_t p, logic [6:0] op);
    applyStimulus(p, p, op, rb(), rb());
  endtask

  task automatic waitMem(phase_t p, logic [6:0] op, int waits);
    for (int i = 0; i < waits; i++) applyStimulus(p, p, op, 1'b0, rb());
    applyStimulus(p, p, op, 1'b1, rb());
  endtask

  task automatic runInstr(logic [6:0] op, int fetchWaits, int memWaits, logic zb);
    waitMem(P_FETCH, op, fetchWaits);
    stepBoth(P_DECODE, op);
    case (op)
      OP_LW:   begin stepBoth(P_MEMADR, op); waitMem(P_MEMRD, op, memWaits); stepBoth(P_MEMWB, op); end
      OP_SW:   begin stepBoth(P_MEMADR, op); waitMem(P_MEMWR, op, memWaits); end
      OP_R:    begin stepBoth(P_EXECR, op); stepBoth(P_ALUWB, op); end
      OP_I:    begin stepBoth(P_EXECI, op); stepBoth(P_ALUWB, op); end
      OP_JAL:  begin stepBoth(P_JAL, op); stepBoth(P_ALUWB, op); end
      OP_BEQ:  applyStimulus(P_BEQ, P_BEQ, op, rb(), zb);
      default: ;
    endcase
    cntA++;
    cntB++;
  endtask

  // Asserts reset mid-cycle with MemReady high so the strobe squash is visible.
  task automatic doReset();
    @(negedge clk);
    #2;
    applyInputs(OP_BEQ, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("A.reset", cycNo, actA, phaseOut(P_FETCH, 1'b0, 1'b0), busA.InstrCount, 32'd0);
    checkOutput("B.reset", cycNo, actB, phaseOut(P_FETCH, 1'b0, 1'b0), 32'(busB.InstrCount), 32'd0);
    applyInputs(OP_BEQ, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    cntA  = '0;
    cntB  = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (qA.size() > 0) begin
        e = qA.pop_front();
        checkOutput({"A.", e.ph.name()}, e.cyc, actA, e.o, busA.InstrCount, e.cnt);
      end
      if (qB.size() > 0) begin
        e = qB.pop_front();
        checkOutput({"B.", e.ph.name()}, e.cyc, actB, e.o, 32'(busB.InstrCount), e.cnt);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    logic [6:0] ops [6];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
    applyInputs(OP_BEQ, 1'b0, 1'b0);
    doReset();

    runInstr(OP_LW,  0, 0, 1'b0);
    runInstr(OP_R,   0, 0, 1'b0);
    runInstr(OP_I,   0, 0, 1'b0);
    runInstr(OP_BEQ, 0, 0, 1'b1);
    runInstr(OP_BEQ, 0, 0, 1'b0);
    runInstr(OP_SW,  0, 3, 1'b0);
    runInstr(OP_JAL, 1, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      runInstr(ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), rb());
    end

    // Illegal opcode: the trapping instance parks in HALT, the other keeps retiring NOPs.
    applyStimulus(P_FETCH, P_FETCH, OP_BAD, 1'b1, rb());
    stepBoth(P_DECODE, OP_BAD);
    cntB++;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        applyStimulus(P_HALT, P_FETCH, OP_BAD, 1'b1, rb());
      end else begin
        applyStimulus(P_HALT, P_DECODE, OP_BAD, rb(), rb());
        cntB++;
      end
    end
    doReset();

    for (int n = 0; n < 16; n++) runInstr(OP_BEQ, 0, 0, rb());
    runInstr(OP_R, 0, 0, 1'b0);

    applyStimulus(P_FETCH, P_FETCH, OP_LW, 1'b1, rb());
    stepBoth(P_DECODE, OP_LW);
    stepBoth(P_MEMADR, OP_LW);
    applyStimulus(P_MEMRD, P_MEMRD, OP_LW, 1'b0, rb());
    doReset();
    runInstr(OP_I, 0, 0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (qA.size() + qB.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending actual=%0d required=0", qA.size() + qB.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
